// File: rtl/hdmi_cfg_pkg.sv
// rtl/hdmi_cfg_pkg.sv - shared types and constants for the ADV7513 config sequencer
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_ISSUE,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam logic [7:0] ADV7513_ADDR      = 8'h72;
  localparam int         DEFAULT_TABLE_LEN = 20;

  // Table word layout: {slave addr, register, data}
  function automatic logic [7:0] tw_addr(input logic [23:0] w);
    return w[23:16];
  endfunction

  function automatic logic [7:0] tw_reg(input logic [23:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] tw_data(input logic [23:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/hdmi_hpd_debounce.sv
// rtl/hdmi_hpd_debounce.sv - HPD synchroniser and debouncer with single-cycle rise/fall events
module hdmi_hpd_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hpd,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_hpd;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any sample matching the current level restarts the stability count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_fall  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// rtl/hdmi_cfg_sequencer.sv - walks the ADV7513 init table and issues each word as an I2C write
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int TABLE_LEN       = DEFAULT_TABLE_LEN,
  parameter int POWERUP_CYCLES  = 1000000,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int MAX_RETRIES     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_hpd,
  output logic [5:0]  o_table_index,
  input  logic [23:0] i_table_data,
  output logic        o_i2c_req,
  output logic [23:0] o_i2c_data,
  input  logic        i_i2c_done,
  input  logic        i_i2c_ack_err,
  output logic        o_busy,
  output logic        o_config_done,
  output logic        o_config_error
);

  localparam int WAIT_W = $clog2(POWERUP_CYCLES + 1);
  localparam int RTY_W  = $clog2(MAX_RETRIES + 2);

  cfg_state_t        r_state;
  logic [5:0]        r_table_index;
  logic              r_i2c_req;
  logic [23:0]       r_i2c_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [RTY_W-1:0]  r_retries;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_fetch_cnt;
  logic              r_pend;
  logic              r_pend_idle;

  logic w_hpd_rise;
  logic w_hpd_fall;
  logic w_rise;
  logic w_fall;
  logic w_evt;
  logic w_pend_any;
  logic w_pend_idle;

  hdmi_hpd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hpd_debounce (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_hpd  (i_hpd),
    .o_rise (w_hpd_rise),
    .o_fall (w_hpd_fall)
  );

  assign w_rise      = i_start | w_hpd_rise;
  assign w_fall      = w_hpd_fall;
  assign w_evt       = w_rise | w_fall;
  // An event in the current cycle is newer than anything already latched
  assign w_pend_any  = w_evt | r_pend;
  assign w_pend_idle = w_evt ? w_fall : r_pend_idle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_table_index <= '0;
      r_i2c_req     <= 1'b0;
      r_i2c_data    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_retries     <= '0;
      r_wait_cnt    <= '0;
      r_fetch_cnt   <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_idle   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_WAIT;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            r_retries  <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_retries <= '0;
          end else if (w_rise) begin
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(POWERUP_CYCLES - 1)) begin
            r_table_index <= '0;
            r_fetch_cnt   <= 1'b0;
            r_state       <= ST_FETCH;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_retries <= '0;
          end else if (w_rise) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
            r_retries  <= '0;
          end else if (r_fetch_cnt) begin
            r_i2c_data <= i_table_data;
            r_i2c_req  <= 1'b1;
            r_state    <= ST_ISSUE;
          end else begin
            r_fetch_cnt <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_i2c_req && !i_i2c_done) begin
            // Transaction in flight: never abort the I2C master, remember the event
            if (w_evt) begin
              r_pend      <= 1'b1;
              r_pend_idle <= w_fall;
            end
          end else if (w_pend_any) begin
            r_i2c_req   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_idle <= 1'b0;
            r_retries   <= '0;
            if (w_pend_idle) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= '0;
            end
          end else if (!r_i2c_req) begin
            r_i2c_req <= 1'b1;
          end else begin
            r_i2c_req <= 1'b0;
            if (!i_i2c_ack_err) begin
              r_state <= ST_NEXT;
            end else if (r_retries == RTY_W'(MAX_RETRIES)) begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_retries <= r_retries + 1'b1;
            end
          end
        end
        ST_NEXT: begin
          r_retries <= '0;
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_rise) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end else if (r_table_index == 6'(TABLE_LEN - 1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_table_index <= r_table_index + 6'd1;
            r_fetch_cnt   <= 1'b0;
            r_state       <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end else if (w_rise) begin
            r_state    <= ST_WAIT;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            r_retries  <= '0;
            r_done     <= 1'b0;
          end
        end
        ST_ERROR: begin
          if (w_rise) begin
            r_state    <= ST_WAIT;
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            r_retries  <= '0;
            r_error    <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_table_index  = r_table_index;
  assign o_i2c_req      = r_i2c_req;
  assign o_i2c_data     = r_i2c_data;
  assign o_busy         = r_busy;
  assign o_config_done  = r_done;
  assign o_config_error = r_error;

endmodule
